hwpe_stream_parity_checker: RTL and testbench

- Transaction-level successor to the lockstep parity sink.
- Checks a monitored normal HWPE stream against its parity shadow stream, one parity bit per strobe element.
- Tolerates a bounded handshake skew between the two networks, because the parity network may run up to SKEW_DEPTH transactions ahead or behind.
- Reports classified faults (sticky cause bits, pulse, saturating fault counter) and detects lost transactions by timeout. Sits at every stream endpoint of a parity-protected HWPE datapath.

---
 rtl/hwpe_stream_package.sv | 22 ++
 rtl/hwpe_stream_intf_stream.sv | 14 +
 rtl/hwpe_stream_parity_skew_buf.sv | 75 +++++++
 rtl/hwpe_stream_parity_checker.sv | 141 ++++++++++++++
 tb/tb_hwpe_stream_parity_checker.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/hwpe_stream_package.sv
// rtl/hwpe_stream_package.sv - shared HWPE stream types for parity checking
package hwpe_stream_package;

    typedef enum logic [1:0] {
        LEADER_NONE   = 2'd0,
        LEADER_NORMAL = 2'd1,
        LEADER_PARITY = 2'd2
    } parity_leader_e;

    typedef struct packed {
        logic timeout;
        logic skew_overflow;
        logic strb_mismatch;
        logic parity_mismatch;
    } parity_fault_cause_t;

    localparam int unsigned CAUSE_PARITY_MISMATCH = 0;
    localparam int unsigned CAUSE_STRB_MISMATCH   = 1;
    localparam int unsigned CAUSE_SKEW_OVERFLOW   = 2;
    localparam int unsigned CAUSE_TIMEOUT         = 3;

endpackage

// File: rtl/hwpe_stream_intf_stream.sv
// rtl/hwpe_stream_intf_stream.sv - HWPE stream handshake interface
interface hwpe_stream_intf_stream #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned STRB_WIDTH = DATA_WIDTH/8
);
    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;
    logic [STRB_WIDTH-1:0] strb;

    modport source  (output valid, data, strb, input ready);
    modport sink    (input valid, data, strb, output ready);
    modport monitor (input valid, ready, data, strb);
endinterface

// File: rtl/hwpe_stream_parity_skew_buf.sv
// rtl/hwpe_stream_parity_skew_buf.sv - FIFO of unmatched entries from the leading stream
module hwpe_stream_parity_skew_buf
    import hwpe_stream_package::*;
#(
    parameter int unsigned SKEW_DEPTH = 2,
    parameter int unsigned ENTRY_W    = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               clear,
    input  logic               flush,
    input  logic               push,
    input  parity_leader_e     push_side,
    input  logic [ENTRY_W-1:0] push_data,
    input  logic               pop,
    output logic [ENTRY_W-1:0] head,
    output logic               empty,
    output logic               full,
    output parity_leader_e     leader
);
    localparam int unsigned CNT_W = $clog2(SKEW_DEPTH + 1);
    localparam int unsigned PTR_W = (SKEW_DEPTH > 1) ? $clog2(SKEW_DEPTH) : 1;

    logic [ENTRY_W-1:0] mem [SKEW_DEPTH];
    logic [PTR_W-1:0]   rd_ptr, wr_ptr;
    logic [CNT_W-1:0]   cnt;

    function automatic logic [PTR_W-1:0] incr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(SKEW_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign head  = mem[rd_ptr];
    assign empty = (cnt == '0);
    assign full  = (cnt == CNT_W'(SKEW_DEPTH));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
            leader <= LEADER_NONE;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
            leader <= LEADER_NONE;
        end else if (flush) begin
            // A push arriving with a flush becomes the sole surviving entry
            rd_ptr <= '0;
            if (push) begin
                wr_ptr <= incr('0);
                cnt    <= CNT_W'(1);
                leader <= push_side;
            end else begin
                wr_ptr <= '0;
                cnt    <= '0;
                leader <= LEADER_NONE;
            end
        end else begin
            if (push) wr_ptr <= incr(wr_ptr);
            if (pop)  rd_ptr <= incr(rd_ptr);
            if (push && !pop) begin
                cnt    <= cnt + 1'b1;
                leader <= push_side;
            end else if (pop && !push) begin
                cnt <= cnt - 1'b1;
                if (cnt == CNT_W'(1)) leader <= LEADER_NONE;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push && !clear) mem[flush ? '0 : wr_ptr] <= push_data;
    end
endmodule

// File: rtl/hwpe_stream_parity_checker.sv
// rtl/hwpe_stream_parity_checker.sv - skew-tolerant checker of a stream against its parity shadow
module hwpe_stream_parity_checker
    import hwpe_stream_package::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned STRB_WIDTH     = DATA_WIDTH/8,
    parameter int unsigned SKEW_DEPTH     = 2,
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned COUNT_WIDTH    = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clear_i,
    hwpe_stream_intf_stream.monitor normal_i,
    hwpe_stream_intf_stream.sink    parity_i,
    output logic                   fault_o,
    output logic [3:0]             fault_cause_o,
    output logic [COUNT_WIDTH-1:0] fault_count_o
);
    localparam int unsigned ELEM_W  = DATA_WIDTH / STRB_WIDTH;
    localparam int unsigned ENTRY_W = 2 * STRB_WIDTH;
    localparam int unsigned TIMER_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST =
        TIMER_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    logic [STRB_WIDTH-1:0] exp_parity;
    logic [ENTRY_W-1:0]    n_entry, p_entry, head, push_data, cmp_a, cmp_b;
    logic                  n_hs, p_hs, empty, full, push, pop, flush, cmp_en;
    parity_leader_e        leader, push_side;
    parity_fault_cause_t   cause;
    logic [TIMER_W-1:0]    timer_q;

    always_comb begin
        exp_parity = '0;
        for (int i = 0; i < STRB_WIDTH; i++) exp_parity[i] = ^normal_i.data[i*ELEM_W +: ELEM_W];
    end

    assign n_entry        = {normal_i.strb, exp_parity};
    assign p_entry        = {parity_i.strb, parity_i.data};
    assign parity_i.ready = clear_i || !(leader == LEADER_PARITY && full);
    assign n_hs           = normal_i.valid && normal_i.ready;
    assign p_hs           = parity_i.valid && parity_i.ready;

    always_comb begin
        cause     = '0;
        push      = 1'b0;
        push_side = LEADER_NONE;
        push_data = '0;
        pop       = 1'b0;
        flush     = 1'b0;
        cmp_en    = 1'b0;
        cmp_a     = '0;
        cmp_b     = '0;
        if (!clear_i) begin
            if (n_hs && p_hs) begin
                cmp_en = 1'b1;
                if (empty) begin
                    cmp_a = n_entry;
                    cmp_b = p_entry;
                end else begin
                    // Head pairs with the trailing side; the leading side's beat takes its place
                    pop       = 1'b1;
                    push      = 1'b1;
                    push_side = leader;
                    cmp_a     = head;
                    cmp_b     = (leader == LEADER_NORMAL) ? p_entry : n_entry;
                    push_data = (leader == LEADER_NORMAL) ? n_entry : p_entry;
                end
            end else if (n_hs) begin
                if (leader == LEADER_PARITY) begin
                    pop    = 1'b1;
                    cmp_en = 1'b1;
                    cmp_a  = head;
                    cmp_b  = n_entry;
                end else if (full) begin
                    cause.skew_overflow = 1'b1;
                end else begin
                    push      = 1'b1;
                    push_side = LEADER_NORMAL;
                    push_data = n_entry;
                end
            end else if (p_hs) begin
                if (leader == LEADER_NORMAL) begin
                    pop    = 1'b1;
                    cmp_en = 1'b1;
                    cmp_a  = head;
                    cmp_b  = p_entry;
                end else begin
                    push      = 1'b1;
                    push_side = LEADER_PARITY;
                    push_data = p_entry;
                end
            end
            if (cmp_en) begin
                cause.strb_mismatch   = cmp_a[ENTRY_W-1:STRB_WIDTH] != cmp_b[ENTRY_W-1:STRB_WIDTH];
                cause.parity_mismatch = cmp_a[STRB_WIDTH-1:0] != cmp_b[STRB_WIDTH-1:0];
            end
            if (TIMEOUT_CYCLES != 0 && !empty && !pop && timer_q == TIMER_LAST) begin
                cause.timeout = 1'b1;
                flush         = 1'b1;
            end
        end
    end

    hwpe_stream_parity_skew_buf #(
        .SKEW_DEPTH (SKEW_DEPTH),
        .ENTRY_W    (ENTRY_W)
    ) i_skew_buf (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clear     (clear_i),
        .flush     (flush),
        .push      (push),
        .push_side (push_side),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .empty     (empty),
        .full      (full),
        .leader    (leader)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            timer_q       <= '0;
            fault_o       <= 1'b0;
            fault_cause_o <= '0;
            fault_count_o <= '0;
        end else if (clear_i) begin
            timer_q       <= '0;
            fault_o       <= 1'b0;
            fault_cause_o <= '0;
            fault_count_o <= '0;
        end else begin
            timer_q       <= (flush || empty || pop) ? '0 : timer_q + 1'b1;
            fault_o       <= |cause;
            fault_cause_o <= fault_cause_o | cause;
            if (|cause && fault_count_o != '1) fault_count_o <= fault_count_o + 1'b1;
        end
    end
endmodule

// File: tb/tb_hwpe_stream_parity_checker.sv
// tb/tb_hwpe_stream_parity_checker.sv - randomized bench against a queue-based reference model
module tb_hwpe_stream_parity_checker;
    localparam int SKEW    = 2;
    localparam int TIMEOUT = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clear;
    logic       fault;
    logic [3:0] fault_cause;
    logic [7:0] fault_count;

    hwpe_stream_intf_stream #(.DATA_WIDTH(32), .STRB_WIDTH(4)) normal ();
    hwpe_stream_intf_stream #(.DATA_WIDTH(4),  .STRB_WIDTH(4)) parity ();

    hwpe_stream_parity_checker #(
        .DATA_WIDTH     (32),
        .STRB_WIDTH     (4),
        .SKEW_DEPTH     (SKEW),
        .TIMEOUT_CYCLES (TIMEOUT),
        .COUNT_WIDTH    (8)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .clear_i       (clear),
        .normal_i      (normal.monitor),
        .parity_i      (parity.sink),
        .fault_o       (fault),
        .fault_cause_o (fault_cause),
        .fault_count_o (fault_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: pending entries of the leading side, 0=none 1=normal 2=parity
    logic [7:0] mq[$];
    int         m_leader, m_timer, m_count;
    bit         m_fault;
    logic [3:0] m_cause;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] ref_parity(input logic [31:0] d);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = ($countones(d[i*8 +: 8]) % 2) == 1;
        return r;
    endfunction

    function automatic logic [3:0] ref_cmp(input logic [7:0] a, input logic [7:0] b);
        return {2'b00, a[7:4] != b[7:4], a[3:0] != b[3:0]};
    endfunction

    task automatic model_reset();
        mq.delete();
        m_leader = 0; m_timer = 0; m_count = 0; m_fault = 0; m_cause = '0;
    endtask

    task automatic model_step(input bit n_hs, input bit p_hs, input logic [7:0] ne,
                              input logic [7:0] pe, input bit clr);
        logic [3:0] raised;
        logic [7:0] head, pushed_e;
        int start_size, pushed_side;
        bit popped, pushed;
        raised = '0; popped = 0; pushed = 0; pushed_e = '0; pushed_side = 0;
        start_size = mq.size();
        if (clr) begin
            model_reset();
            return;
        end
        if (n_hs && p_hs) begin
            if (start_size == 0) raised |= ref_cmp(ne, pe);
            else begin
                head = mq.pop_front(); popped = 1; pushed = 1; pushed_side = m_leader;
                pushed_e = (m_leader == 1) ? ne : pe;
                raised |= ref_cmp(head, (m_leader == 1) ? pe : ne);
                mq.push_back(pushed_e);
            end
        end else if (n_hs) begin
            if (m_leader == 2) begin head = mq.pop_front(); popped = 1; raised |= ref_cmp(head, ne); end
            else if (start_size == SKEW) raised |= 4'b0100;
            else begin mq.push_back(ne); m_leader = 1; pushed = 1; pushed_e = ne; pushed_side = 1; end
        end else if (p_hs) begin
            if (m_leader == 1) begin head = mq.pop_front(); popped = 1; raised |= ref_cmp(head, pe); end
            else begin mq.push_back(pe); m_leader = 2; pushed = 1; pushed_e = pe; pushed_side = 2; end
        end
        if (start_size > 0 && !popped && m_timer == TIMEOUT - 1) begin
            raised |= 4'b1000;
            mq.delete();
            m_leader = 0;
            if (pushed) begin mq.push_back(pushed_e); m_leader = pushed_side; end
            m_timer = 0;
        end else if (start_size == 0 || popped) m_timer = 0;
        else m_timer++;
        if (mq.size() == 0) m_leader = 0;
        m_fault = raised != 0;
        m_cause |= raised;
        if (raised != 0 && m_count < 255) m_count++;
    endtask

    // Called at a falling edge; returns at the next falling edge
    task automatic drive_cycle(input bit nv, input bit nr, input logic [31:0] nd, input logic [3:0] ns,
                               input bit pv, input logic [3:0] pd, input logic [3:0] ps, input bit clr);
        bit exp_ready;
        normal.valid = nv; normal.ready = nr; normal.data = nd; normal.strb = ns;
        parity.valid = pv; parity.data = pd; parity.strb = ps; clear = clr;
        exp_ready = clr || !(m_leader == 2 && mq.size() == SKEW);
        #1;
        check_eq("parity_ready", parity.ready, exp_ready);
        model_step(nv && nr, pv && exp_ready, {ns, ref_parity(nd)}, {ps, pd}, clr);
        @(posedge clk);
        #1;
        check_eq("fault", fault, m_fault);
        check_eq("cause", fault_cause, m_cause);
        check_eq("count", fault_count, m_count);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle(0, 1, '0, '0, 0, '0, '0, 0);
    endtask

    task automatic lockstep(input logic [31:0] nd, input logic [3:0] ns,
                            input logic [3:0] pd, input logic [3:0] ps);
        drive_cycle(1, 1, nd, ns, 1, pd, ps, 0);
    endtask

    task automatic async_reset();
        rst_n = 1'b0;
        #1;
        check_eq("rst_fault", fault, 0);
        check_eq("rst_cause", fault_cause, 0);
        check_eq("rst_count", fault_count, 0);
        check_eq("rst_ready", parity.ready, 1);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] d1, d2, rd;
        model_reset();
        rst_n = 1'b0; clear = 1'b0;
        normal.valid = 0; normal.ready = 1; normal.data = '0; normal.strb = '0;
        parity.valid = 0; parity.data = '0; parity.strb = '0;
        repeat (3) @(negedge clk);
        check_eq("reset_fault", fault, 0);
        check_eq("reset_cause", fault_cause, 0);
        check_eq("reset_count", fault_count, 0);
        rst_n = 1'b1;

        lockstep(32'h0000_0103, 4'hF, ref_parity(32'h0000_0103), 4'hF);
        check_eq("lockstep_count", fault_count, 0);

        d1 = 32'h1234_5678; d2 = 32'h00FF_0107;
        drive_cycle(0, 1, '0, '0, 1, ref_parity(d1), 4'hF, 0);
        drive_cycle(0, 1, '0, '0, 1, ref_parity(d2), 4'hF, 0);
        normal.valid = 0; parity.valid = 1;
        #1;
        check_eq("lead_ready_low", parity.ready, 0);
        drive_cycle(0, 1, '0, '0, 1, 4'h0, 4'hF, 0);
        drive_cycle(1, 1, d1, 4'hF, 0, '0, '0, 0);
        drive_cycle(1, 1, d2, 4'hF, 0, '0, '0, 0);
        check_eq("lead_count", fault_count, 0);
        idle(TIMEOUT + 2);
        check_eq("lead_no_timeout", fault_count, 0);

        drive_cycle(0, 1, '0, '0, 0, '0, '0, 1);
        lockstep(32'h0000_0001, 4'hF, 4'h0, 4'hF);
        check_eq("flip_fault", fault, 1);
        check_eq("flip_cause", fault_cause, 4'b0001);
        check_eq("flip_count", fault_count, 1);

        drive_cycle(0, 1, '0, '0, 0, '0, '0, 1);
        lockstep(32'h0000_0001, 4'hF, 4'h0, 4'h7);
        check_eq("dual_cause", fault_cause, 4'b0011);
        check_eq("dual_count", fault_count, 1);

        drive_cycle(0, 1, '0, '0, 0, '0, '0, 1);
        for (int i = 0; i < 3; i++) drive_cycle(1, 1, 32'(i), 4'hF, 0, '0, '0, 0);
        check_eq("ovf_cause", fault_cause, 4'b0100);
        check_eq("ovf_count", fault_count, 1);
        idle(8);
        check_eq("tmo_cause", fault_cause, 4'b1100);
        check_eq("tmo_count", fault_count, 2);

        drive_cycle(0, 1, '0, '0, 0, '0, '0, 1);
        for (int i = 0; i < 300; i++) lockstep(32'h0000_0001, 4'hF, 4'h0, 4'hF);
        check_eq("sat_count", fault_count, 8'hFF);
        drive_cycle(0, 1, '0, '0, 0, '0, '0, 1);
        check_eq("clr_fault", fault, 0);
        check_eq("clr_cause", fault_cause, 0);
        check_eq("clr_count", fault_count, 0);
        drive_cycle(1, 1, 32'hDEAD_BEEF, 4'hF, 0, '0, '0, 0);
        drive_cycle(0, 1, '0, '0, 0, '0, '0, 0);
        async_reset();
        idle(TIMEOUT + 2);
        check_eq("post_rst_count", fault_count, 0);

        for (int i = 0; i < 3000; i++) begin
            rd = $urandom;
            drive_cycle($urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0, rd,
                        ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF,
                        $urandom_range(0, 1) == 1,
                        ($urandom_range(0, 1) == 1) ? ref_parity(rd) : 4'($urandom),
                        ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF,
                        $urandom_range(0, 49) == 0);
            if (i == 1500) async_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
